// File: rtl/iob_mem_responder_if.sv
// ---------------------------------------------------------------------------
// iob_mem_responder_if
//
// Bus bundle between an initiator and the iob_mem_responder memory model.
//
//   req   : {valid, addr[ADDR_W-1:0], wdata[DATA_W-1:0], wstrb[DATA_W/8-1:0]}
//           driven by the initiator (master)
//   resp  : {rdata[DATA_W-1:0], ready} driven by the responder (slave)
//   stall : initiator-driven wait-state request; freezes the responder's
//           latency countdown while high
// ---------------------------------------------------------------------------
interface iob_mem_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int REQ_W = 1 + ADDR_W + DATA_W + DATA_W / 8;

    logic [REQ_W-1:0]  req;
    logic [DATA_W:0]   resp;
    logic              stall;

    modport master (
        output req,
        output stall,
        input  resp
    );

    modport slave (
        input  req,
        input  stall,
        output resp
    );
endinterface

// File: rtl/iob_mem_responder.sv
// ---------------------------------------------------------------------------
// iob_mem_responder
//
// Word-addressed memory behind a simple valid/ready request bus with a
// programmable response latency and an initiator-controlled stall.
//
// Ports
//   clk    : single clock, all state changes on its rising edge
//   rst_n  : asynchronous, active-low reset
//   bus    : iob_mem_responder_if.slave
//              bus.req   {valid, addr, wdata, wstrb}   (input)
//              bus.resp  {rdata, ready}                (output, registered)
//              bus.stall countdown freeze              (input)
//
// Parameters
//   ADDR_W      request address width
//   DATA_W      data width (32 only)
//   MEM_ADDR_W  log2 of memory depth in words
//   LATENCY     1..15, cycles from acceptance to ready
//
// States
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no request outstanding; a valid request is accepted at the edge
//   BUSY  | request outstanding; countdown running, or ready cycle when
//         | ready_q=1 (in which a new request may be accepted back-to-back)
//
// Timing model: the countdown is loaded with LATENCY-1 at acceptance. The
// edge at which it reaches zero (with stall low) also raises ready, so
// ready is visible in the following cycle and is sampled by the initiator
// LATENCY edges after acceptance. For LATENCY=1 the countdown is already
// zero at acceptance, so ready rises at the accepting edge itself; this is
// what lets back-to-back requests return one pulse every LATENCY cycles.
// ---------------------------------------------------------------------------
module iob_mem_responder #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 10,
    parameter int LATENCY    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    iob_mem_responder_if.slave bus
);

    localparam int STRB_W    = DATA_W / 8;
    localparam int MEM_DEPTH = 1 << MEM_ADDR_W;
    localparam int CNT_W     = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Request bus unpacking
    logic                  req_valid;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [STRB_W-1:0]     req_wstrb;
    logic [MEM_ADDR_W-1:0] req_idx;
    logic                  unused_addr_bits;

    assign {req_valid, req_addr, req_wdata, req_wstrb} = bus.req;

    // Byte-address to word index; bits outside the index are dropped, so
    // larger addresses alias onto the memory.
    assign req_idx          = req_addr[MEM_ADDR_W+1:2];
    assign unused_addr_bits = ^req_addr;

    // Registered state
    state_t                state_q,  state_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic                  ready_q,  ready_d;
    logic [DATA_W-1:0]     rdata_q,  rdata_d;
    logic [MEM_ADDR_W-1:0] idx_q,    idx_d;
    logic [STRB_W-1:0]     wstrb_q,  wstrb_d;

    logic                  accept;
    logic                  mem_we;

    // Storage; intentionally not reset so it survives a reset pulse.
    logic [DATA_W-1:0]     mem_q [MEM_DEPTH];

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        rdata_d = rdata_q;
        idx_d   = idx_q;
        wstrb_d = wstrb_q;
        accept  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                accept = req_valid;
            end

            ST_BUSY: begin
                if (ready_q) begin
                    // Ready cycle: the bus already carries the next request.
                    accept = req_valid;
                    if (!req_valid) begin
                        state_d = ST_IDLE;
                    end
                end else if (!bus.stall) begin
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        ready_d = 1'b1;
                        rdata_d = (wstrb_q == '0) ? mem_q[idx_q] : '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Acceptance overrides the per-state updates above. The latched
        // write data is not kept: writes commit at this very edge.
        if (accept) begin
            state_d = ST_BUSY;
            cnt_d   = CNT_LOAD;
            idx_d   = req_idx;
            wstrb_d = req_wstrb;
            if (CNT_LOAD == '0) begin
                // Zero remaining countdown: respond at the accepting edge.
                // The memory read sees contents before this edge's write,
                // which cannot target this request since it is a read.
                ready_d = 1'b1;
                rdata_d = (req_wstrb == '0) ? mem_q[req_idx] : '0;
            end
        end
    end

    assign mem_we = accept && (req_wstrb != '0);

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            idx_q   <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            idx_q   <= idx_d;
            wstrb_q <= wstrb_d;
        end
    end

    // -----------------------------------------------------------------------
    // Byte-lane write port
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (req_wstrb[i]) begin
                    mem_q[req_idx][i*8 +: 8] <= req_wdata[i*8 +: 8];
                end
            end
        end
    end

    // Response is taken straight from flops.
    assign bus.resp = {rdata_q, ready_q};

endmodule
